mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter that shares the single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between both units and the memory slave. It accepts one request at a time, registers it, and forwards it over a valid/ready request channel. It then routes the memory response back to the granted master. Only one transaction is outstanding at any time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MASK_W, 8, write byte-mask width (matches the existing store mask)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU read data valid
- ifu_resp_ready  in  1  IFU can take response
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wdata  in  DATA_W  LSU store data
- lsu_wmask  in  MASK_W  LSU store byte mask
- lsu_wen  in  1  1 = write, 0 = read
- lsu_resp_valid  out  1  LSU response (read data or write ack)
- lsu_resp_ready  in  1  LSU can take response
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wdata, mem_wmask, mem_wen  out  ADDR_W/DATA_W/MASK_W/1  registered request fields
- mem_resp_valid  in  1  memory response
- mem_resp_ready  out  1  response accepted
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE:
    - req_ready is high only for the selected master.
    - On a request handshake (fire), latch addr, wdata, wmask and wen into registers, record the owner, and go to REQ.
    - For IFU requests, wen=0 and wmask=0 are latched.
  - REQ: mem_req_valid=1; fields are held stable. When mem_req_ready is high, go to RESP.
  - RESP:
    - mem_resp_ready = owner's resp_ready.
    - owner's resp_valid = mem_resp_valid.
    - When the response fires, go to IDLE.
- The non-owner's resp_valid is always 0. Both rdata outputs carry mem_rdata directly (combinational pass-through).
- Selection happens in IDLE only:
  - A single requester always wins.
  - On a tie, the winner is set by the arbitration policy (see Configuration).
- Writes complete only after the memory response. The LSU always sees exactly one resp per accepted request.
- A request is never accepted outside IDLE; both req_ready outputs are 0 in REQ and RESP.
- A default or illegal state returns to IDLE.

## Timing
- Reset (rst low, asynchronous):
  - state = IDLE, owner = IFU, last_grant = IFU.
  - mem_req_valid = 0; mem_addr, mem_wdata, mem_wmask and mem_wen = 0.
  - All resp_valid = 0, busy = 0.
- Reset mid-operation drops the in-flight transaction; no response is delivered. The memory slave shares the same reset.
- Request accepted at edge N → mem_req_valid high from cycle N+1.
- With zero-wait memory (ready and resp in consecutive cycles), the master sees resp_valid at N+2. The earliest next acceptance is the cycle after the resp fire, so back-to-back throughput is one transaction per 3 cycles.
- Master-side backpressure: resp_ready low holds RESP, and mem_resp_ready stays low with it.
- Memory-side backpressure: mem_req_ready low holds REQ indefinitely with fields unchanged.
- A master dropping req_valid before acceptance is legal; nothing is latched.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a tie, grant the master that was not granted last.
  - last_grant updates on every accepted request.
  - After reset, the first tie goes to the LSU.
- Undefined: fixed priority; LSU always wins ties. last_grant is not implemented.

## Structure
- Shared package npc_mem_pkg holds:
  - state encoding (IDLE=0, REQ=1, RESP=2)
  - master ID constants (MID_IFU=0, MID_LSU=1)
  - default widths
- One sub-module, arb_pick2: combinational 2-way picker. It takes the two valids and last_grant, and outputs the grant. Its round-robin logic sits under the macro.
- The FSM, field registers and response routing stay in mem_arbiter.

## Test plan
- IFU-only read, addr 0x8000_0000, memory returns 0xDEAD_BEEF with zero wait → ifu_resp_valid at N+2 with rdata 0xDEAD_BEEF; lsu_resp_valid stays 0.
- LSU write, addr 0x8000_0010, wdata 0x1234_5678, wmask 0x0F → mem fields exactly match in REQ; one lsu_resp_valid pulse; mem_wen=1.
- Simultaneous IFU+LSU requests for 4 rounds:
  - With ARB_ROUND_ROBIN_EN, grants are LSU, IFU, LSU, IFU.
  - Without it, grants are LSU×4 and the IFU is served only after the LSU drops req_valid.
- mem_req_ready held low 5 cycles, then mem_resp_valid with lsu_resp_ready low 3 cycles → fields stable throughout; busy=1; both req_ready=0; exactly one response delivered.
- rst asserted during RESP → all outputs at reset values immediately. After release, a fresh IFU read completes normally with no stale response.

Source files
------------

// File: rtl/npc_mem_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding,
// master IDs and default bus widths.
package npc_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    MID_IFU = 1'b0,
    MID_LSU = 1'b1
  } mid_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle around the arbiter: IFU port, LSU port and memory port.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding units (IFU, LSU and memory slave) that drive its inputs.
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// valid and ready are both high; once raised by the arbiter, mem_req_valid
// and the mem_* request fields stay stable until mem_req_ready is seen.
interface mem_arbiter_if
  import npc_mem_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W,
  parameter int MW = MASK_W
);
  logic          ifu_req_valid;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid;
  logic          ifu_resp_ready;
  logic [DW-1:0] ifu_rdata;

  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [MW-1:0] lsu_wmask;
  logic          lsu_wen;
  logic          lsu_resp_valid;
  logic          lsu_resp_ready;
  logic [DW-1:0] lsu_rdata;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_wen;
  logic          mem_resp_valid;
  logic          mem_resp_ready;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wdata, lsu_wmask, lsu_wen, lsu_resp_ready,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wdata, mem_wmask, mem_wen, mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output busy
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wdata, lsu_wmask, lsu_wen, lsu_resp_ready,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wdata, mem_wmask, mem_wen, mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  busy
  );

endinterface

// File: rtl/arb_pick2.sv
// Combinational two-way picker between IFU and LSU.
// Build option ARB_ROUND_ROBIN_EN: ties go to the master not granted last;
// otherwise the LSU always wins ties. Grants are one-hot or zero and are
// only ever raised for a master that is requesting.
module arb_pick2
  import npc_mem_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
`ifdef ARB_ROUND_ROBIN_EN
  input  mid_e last_grant,
`endif
  output logic gnt_ifu,
  output logic gnt_lsu
);

  // Resolve the grant; a lone requester always wins.
  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (ifu_valid && lsu_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt_lsu = (last_grant == MID_IFU);
      gnt_ifu = (last_grant == MID_LSU);
`else
      gnt_lsu = 1'b1;
`endif
    end else begin
      gnt_ifu = ifu_valid;
      gnt_lsu = lsu_valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory port between IFU (read-only) and
// LSU (read/write). One transaction outstanding at a time:
// IDLE (accept + latch) -> REQ (present to memory) -> RESP (route response).
// Build option ARB_ROUND_ROBIN_EN selects round-robin tie-breaking and adds
// the last_grant register; without it the LSU wins every tie.
module mem_arbiter
  import npc_mem_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus,
  output state_e          dbg_state
);

  state_e              state_q, state_d;
  mid_e                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                wen_q,   wen_d;
  logic                gnt_ifu, gnt_lsu;
  logic                owner_resp_ready;
`ifdef ARB_ROUND_ROBIN_EN
  mid_e                last_grant_q, last_grant_d;
`endif

  arb_pick2 u_pick (
    .ifu_valid  (bus.ifu_req_valid),
    .lsu_valid  (bus.lsu_req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .gnt_ifu    (gnt_ifu),
    .gnt_lsu    (gnt_lsu)
  );

  // Next-state, field capture and handshake outputs.
  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    wmask_d            = wmask_q;
    wen_d              = wen_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d       = last_grant_q;
`endif
    owner_resp_ready   = 1'b0;
    bus.ifu_req_ready  = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.mem_resp_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.ifu_req_ready = gnt_ifu;
        bus.lsu_req_ready = gnt_lsu;
        // A grant implies the master is valid, so grant == fire here.
        if (gnt_lsu) begin
          owner_d = MID_LSU;
          addr_d  = bus.lsu_addr;
          wdata_d = bus.lsu_wdata;
          wmask_d = bus.lsu_wmask;
          wen_d   = bus.lsu_wen;
          state_d = ST_REQ;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = MID_LSU;
`endif
        end else if (gnt_ifu) begin
          owner_d = MID_IFU;
          addr_d  = bus.ifu_addr;
          wdata_d = '0;
          wmask_d = '0;
          wen_d   = 1'b0;
          state_d = ST_REQ;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = MID_IFU;
`endif
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        owner_resp_ready   = (owner_q == MID_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;
        bus.mem_resp_ready = owner_resp_ready;
        if (owner_q == MID_LSU) bus.lsu_resp_valid = bus.mem_resp_valid;
        else                    bus.ifu_resp_valid = bus.mem_resp_valid;
        if (bus.mem_resp_valid && owner_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request-field registers; reset drops any in-flight transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= MID_IFU;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      wen_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= MID_IFU;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      wen_q        <= wen_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.mem_req_valid = (state_q == ST_REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.mem_wen       = wen_q;
  assign bus.ifu_rdata     = bus.mem_rdata;
  assign bus.lsu_rdata     = bus.mem_rdata;
  assign bus.busy          = (state_q != ST_IDLE);
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset values, IFU read, LSU write,
// tie-breaking, back-pressure on both sides and reset during a response.
module tb_mem_arbiter;
  import npc_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_e dbg_state;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_resp_ready = 1'b1;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b req_valid=%b state=%0d required 0 0 0",
               bus.busy, bus.mem_req_valid, dbg_state);
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_wmask !== 8'h0 || bus.mem_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_fields addr=%h wdata=%h wmask=%h wen=%b required all 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen);
    end
    checks++;
    if (bus.ifu_resp_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp ifu=%b lsu=%b required 0 0", bus.ifu_resp_valid, bus.lsu_resp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ifu_read();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    bus.mem_req_ready = 1'b1;
    #1;
    checks++;
    if (bus.ifu_req_ready !== 1'b1 || bus.lsu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ifu_ready ifu=%b lsu=%b required 1 0", bus.ifu_req_ready, bus.lsu_req_ready);
    end
    tick();  // accepted at edge N
    bus.ifu_req_valid = 1'b0;
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0000 || bus.mem_wen !== 1'b0 || bus.mem_wmask !== 8'h0) begin
      errors++;
      $display("FAIL ifu_req valid=%b addr=%h wen=%b wmask=%h required 1 80000000 0 00",
               bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask);
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hDEAD_BEEF;
    tick();  // N+1 edge: now in RESP (cycle N+2)
    checks++;
    if (bus.ifu_resp_valid !== 1'b1 || bus.ifu_rdata !== 32'hDEAD_BEEF || bus.lsu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ifu_resp valid=%b rdata=%h lsu_valid=%b required 1 deadbeef 0",
               bus.ifu_resp_valid, bus.ifu_rdata, bus.lsu_resp_valid);
    end
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.ifu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ifu_done busy=%b resp_valid=%b required 0 0", bus.busy, bus.ifu_resp_valid);
    end
    clear_inputs();
  endtask

  task automatic test_lsu_write();
    int pulses;
    pulses = 0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_0010;
    bus.lsu_wdata     = 32'h1234_5678;
    bus.lsu_wmask     = 8'h0F;
    bus.lsu_wen       = 1'b1;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.lsu_req_valid = 1'b0;
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0010 || bus.mem_wdata !== 32'h1234_5678 ||
        bus.mem_wmask !== 8'h0F || bus.mem_wen !== 1'b1) begin
      errors++;
      $display("FAIL lsu_fields valid=%b addr=%h wdata=%h wmask=%h wen=%b required 1 80000010 12345678 0f 1",
               bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen);
    end
    bus.mem_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.lsu_resp_valid === 1'b1) pulses++;
      checks++;
      if (bus.ifu_resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL lsu_wr_ifu_quiet cycle=%0d ifu_resp_valid=%b required 0", i, bus.ifu_resp_valid);
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL lsu_wr_pulses got %0d required 1", pulses);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_tie();
    logic exp_lsu [4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_lsu = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_addr       = 32'h0000_0200;
    bus.lsu_req_valid  = 1'b1;
    bus.lsu_addr       = 32'h0000_0100;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h5555_AAAA;
    #1;
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (bus.lsu_req_ready !== exp_lsu[r] || bus.ifu_req_ready !== !exp_lsu[r]) begin
        errors++;
        $display("FAIL tie_ready round=%0d lsu=%b ifu=%b required lsu=%b", r,
                 bus.lsu_req_ready, bus.ifu_req_ready, exp_lsu[r]);
      end
      tick();
      checks++;
      if (bus.mem_addr !== (exp_lsu[r] ? 32'h0000_0100 : 32'h0000_0200)) begin
        errors++;
        $display("FAIL tie_addr round=%0d addr=%h lsu_expected=%b", r, bus.mem_addr, exp_lsu[r]);
      end
      tick();
      checks++;
      if (bus.lsu_resp_valid !== exp_lsu[r] || bus.ifu_resp_valid !== !exp_lsu[r]) begin
        errors++;
        $display("FAIL tie_resp round=%0d lsu=%b ifu=%b required lsu=%b", r,
                 bus.lsu_resp_valid, bus.ifu_resp_valid, exp_lsu[r]);
      end
      tick();
    end
    // LSU backs off: IFU must now be served.
    bus.lsu_req_valid = 1'b0;
    #1;
    checks++;
    if (bus.ifu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL tie_ifu_after_drop ifu_ready=%b required 1", bus.ifu_req_ready);
    end
    tick();
    bus.ifu_req_valid = 1'b0;
    tick();
    checks++;
    if (bus.ifu_resp_valid !== 1'b1 || bus.ifu_rdata !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL tie_ifu_resp valid=%b rdata=%h required 1 5555aaaa", bus.ifu_resp_valid, bus.ifu_rdata);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    int pulses;
    pulses = 0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_0300;
    bus.lsu_wdata     = 32'hA5A5_0001;
    bus.lsu_wmask     = 8'hF0;
    bus.lsu_wen       = 1'b1;
    tick();
    bus.lsu_req_valid = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h0000_0400;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h0000_0300 || bus.mem_wdata !== 32'hA5A5_0001 ||
          bus.mem_wmask !== 8'hF0 || bus.busy !== 1'b1 || bus.ifu_req_ready !== 1'b0 || bus.lsu_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_req_hold cycle=%0d valid=%b addr=%h wdata=%h wmask=%h busy=%b rdy=%b%b", i,
                 bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.busy,
                 bus.ifu_req_ready, bus.lsu_req_ready);
      end
      tick();
    end
    bus.mem_req_ready = 1'b1;
    tick();  // into RESP
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.lsu_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dbg_state !== ST_RESP || bus.lsu_resp_valid !== 1'b1 || bus.mem_resp_ready !== 1'b0 ||
          bus.ifu_req_ready !== 1'b0 || bus.mem_addr !== 32'h0000_0300) begin
        errors++;
        $display("FAIL bp_resp_hold cycle=%0d state=%0d lsu_valid=%b mem_resp_ready=%b ifu_ready=%b addr=%h",
                 i, dbg_state, bus.lsu_resp_valid, bus.mem_resp_ready, bus.ifu_req_ready, bus.mem_addr);
      end
      tick();
    end
    bus.ifu_req_valid  = 1'b0;
    bus.lsu_resp_ready = 1'b1;
    #1;
    checks++;
    if (bus.mem_resp_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release mem_resp_ready=%b required 1", bus.mem_resp_ready);
    end
    if (bus.lsu_resp_valid === 1'b1) pulses++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.lsu_resp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_one_resp pulses=%0d busy=%b required 1 0", pulses, bus.busy);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_addr       = 32'h8000_0020;
    bus.ifu_resp_ready = 1'b0;
    bus.mem_req_ready  = 1'b1;
    tick();
    bus.ifu_req_valid  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0BAD_0BAD;
    tick();  // now in RESP, held by ifu_resp_ready low
    checks++;
    if (dbg_state !== ST_RESP || bus.ifu_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rm_setup state=%0d resp_valid=%b required 2 1", dbg_state, bus.ifu_resp_valid);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (dbg_state !== ST_IDLE || bus.busy !== 1'b0 || bus.ifu_resp_valid !== 1'b0 ||
        bus.mem_req_valid !== 1'b0 || bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rm_async state=%0d busy=%b resp_valid=%b req_valid=%b addr=%h required all 0",
               dbg_state, bus.busy, bus.ifu_resp_valid, bus.mem_req_valid, bus.mem_addr);
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0040;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.ifu_req_valid = 1'b0;
    checks++;
    if (bus.mem_addr !== 32'h8000_0040 || bus.ifu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_fresh_req addr=%h resp_valid=%b required 80000040 0", bus.mem_addr, bus.ifu_resp_valid);
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hCAFE_F00D;
    tick();
    checks++;
    if (bus.ifu_resp_valid !== 1'b1 || bus.ifu_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL rm_fresh_resp valid=%b rdata=%h required 1 cafef00d", bus.ifu_resp_valid, bus.ifu_rdata);
    end
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.ifu_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_fresh_done busy=%b resp_valid=%b required 0 0", bus.busy, bus.ifu_resp_valid);
    end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_tie();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
